// File: rtl/tl_manual_scheduler_if.sv
// Operator/pedestrian inputs, light FSM feedback and the
// scheduler's control outputs, grouped as one bundle.
interface tl_manual_scheduler_if;
  logic       mode_req;
  logic       req_a;
  logic       req_b;
  logic       preempt;
  logic       preempt_dir;
  logic       green_a;
  logic       green_b;
  logic       fault_clr;
  logic       swap_mode;
  logic       button;
  logic       busy;
  logic       fault;
  logic [1:0] state_o;

  modport master (
    output mode_req, req_a, req_b,
    output preempt, preempt_dir,
    output green_a, green_b, fault_clr,
    input  swap_mode, button, busy,
    input  fault, state_o
  );

  modport slave (
    input  mode_req, req_a, req_b,
    input  preempt, preempt_dir,
    input  green_a, green_b, fault_clr,
    output swap_mode, button, busy,
    output fault, state_o
  );
endinterface

// File: rtl/tl_manual_scheduler.sv
// Manual-mode sequencer for the intersection light FSM:
// grants A/B green with min hold, preempt and handover timeout.
module tl_manual_scheduler #(
  parameter int MIN_HOLD   = 6,
  parameter int SW_TIMEOUT = 8,
  parameter int SETTLE     = 2
) (
  input logic clk_f,
  input logic rst,
  tl_manual_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    SWITCH = 2'd1,
    HOLD   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [7:0] MH = 8'(MIN_HOLD);
  localparam logic [7:0] TO = 8'(SW_TIMEOUT - 1);
  localparam logic [7:0] ST = 8'(SETTLE);

  state_t     state, state_n;
  logic       grant, grant_n;
  logic       pend_a, pend_a_n;
  logic       pend_b, pend_b_n;
  logic [7:0] hold_cnt, hold_n;
  logic [7:0] sw_cnt, sw_n;
  logic       swap_q, swap_n;
  logic       button_q, button_n;
  logic       busy_q, busy_n;
  logic       fault_q, fault_n;

  logic manual, other, tgt_green, pend_oth;
  logic do_pre, do_req;

  assign manual    = bus.mode_req | bus.preempt;
  assign other     = ~grant;
  assign tgt_green = grant ? bus.green_b : bus.green_a;
  assign pend_oth  = grant ? pend_a : pend_b;

  assign do_pre = bus.preempt &&
                  (bus.preempt_dir != grant);
  assign do_req = !bus.preempt && pend_oth &&
                  (hold_cnt >= MH);

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    pend_a_n = pend_a;
    pend_b_n = pend_b;
    hold_n   = hold_cnt;
    sw_n     = sw_cnt;
    swap_n   = swap_q;
    button_n = button_q;
    fault_n  = fault_q;
    unique case (state)
      AUTO: begin
        pend_a_n = 1'b0;
        pend_b_n = 1'b0;
        swap_n   = 1'b0;
        button_n = 1'b0;
        if (manual) begin
          state_n = SWITCH;
          grant_n = 1'b0;
          swap_n  = 1'b1;
          sw_n    = 8'd0;
        end
      end
      SWITCH: begin
        sw_n     = sw_cnt + 8'd1;
        pend_a_n = pend_a | bus.req_a;
        pend_b_n = pend_b | bus.req_b;
        if (sw_cnt >= ST && tgt_green) begin
          state_n = HOLD;
          hold_n  = 8'd0;
          if (grant) pend_b_n = 1'b0;
          else       pend_a_n = 1'b0;
        end else if (sw_cnt == TO) begin
          state_n  = FAULT;
          fault_n  = 1'b1;
          swap_n   = 1'b0;
          button_n = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt != 8'hFF)
          hold_n = hold_cnt + 8'd1;
        // the side already holding green cannot request itself
        pend_a_n = pend_a | (bus.req_a & grant);
        pend_b_n = pend_b | (bus.req_b & ~grant);
        if (!manual) begin
          state_n  = AUTO;
          swap_n   = 1'b0;
          button_n = 1'b0;
        end else if (do_pre || do_req) begin
          state_n  = SWITCH;
          grant_n  = other;
          button_n = other;
          sw_n     = 8'd0;
        end
      end
      FAULT: begin
        pend_a_n = 1'b0;
        pend_b_n = 1'b0;
        swap_n   = 1'b0;
        button_n = 1'b0;
        fault_n  = 1'b1;
        if (bus.fault_clr && !manual) begin
          state_n = AUTO;
          fault_n = 1'b0;
        end
      end
      default: state_n = AUTO;
    endcase
    busy_n = (state_n == SWITCH);
  end

  always_ff @(posedge clk_f) begin
    if (rst) begin
      state    <= AUTO;
      grant    <= 1'b0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      hold_cnt <= 8'd0;
      sw_cnt   <= 8'd0;
      swap_q   <= 1'b0;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      pend_a   <= pend_a_n;
      pend_b   <= pend_b_n;
      hold_cnt <= hold_n;
      sw_cnt   <= sw_n;
      swap_q   <= swap_n;
      button_q <= button_n;
      busy_q   <= busy_n;
      fault_q  <= fault_n;
    end
  end

  assign bus.swap_mode = swap_q;
  assign bus.button    = button_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_tl_manual_scheduler.sv
// Directed bench for tl_manual_scheduler: reset, entry,
// request switch, preempt, timeout/fault, mode drop and rst.
module tb_tl_manual_scheduler;

  logic clk_f = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  tl_manual_scheduler_if bus ();

  tl_manual_scheduler dut (
    .clk_f (clk_f),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_f = ~clk_f;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_f);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] st,
                         input logic sw,
                         input logic bt,
                         input logic bz,
                         input logic ft);
    chk({tag, ".state"}, 8'(bus.state_o), 8'(st));
    chk({tag, ".swap"}, 8'(bus.swap_mode), 8'(sw));
    chk({tag, ".button"}, 8'(bus.button), 8'(bt));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(bz));
    chk({tag, ".fault"}, 8'(bus.fault), 8'(ft));
  endtask

  initial begin
    rst             = 1'b1;
    bus.mode_req    = 1'b0;
    bus.req_a       = 1'b0;
    bus.req_b       = 1'b0;
    bus.preempt     = 1'b0;
    bus.preempt_dir = 1'b0;
    bus.green_a     = 1'b0;
    bus.green_b     = 1'b0;
    bus.fault_clr   = 1'b0;
    tick(2);
    chk_all("reset", 2'd0, 0, 0, 0, 0);
    rst = 1'b0;

    // manual entry lands on A
    bus.mode_req = 1'b1;
    tick();
    chk_all("entry", 2'd1, 1, 0, 1, 0);
    bus.green_a = 1'b1;
    tick(2);
    chk_all("settle", 2'd1, 1, 0, 1, 0);
    tick();
    chk_all("hold_a", 2'd2, 1, 0, 0, 0);

    // req_b seen at hold_cnt=2, switch at hold_cnt=6
    tick(2);
    bus.req_b = 1'b1;
    tick();
    bus.req_b = 1'b0;
    tick(3);
    chk_all("minhold", 2'd2, 1, 0, 0, 0);
    tick();
    chk_all("sw_to_b", 2'd1, 1, 1, 1, 0);
    bus.green_a = 1'b0;
    bus.green_b = 1'b1;
    tick(2);
    chk("sw_b.state", 8'(bus.state_o), 8'd1);
    tick();
    chk_all("hold_b", 2'd2, 1, 1, 0, 0);

    // preempt to A bypasses min hold
    bus.preempt     = 1'b1;
    bus.preempt_dir = 1'b0;
    tick();
    chk_all("pre_a", 2'd1, 1, 0, 1, 0);
    bus.green_b = 1'b0;
    bus.green_a = 1'b1;
    tick(3);
    chk_all("pre_hold_a", 2'd2, 1, 0, 0, 0);
    tick();
    bus.preempt_dir = 1'b1;
    tick();
    chk_all("pre_b", 2'd1, 1, 1, 1, 0);
    bus.green_a = 1'b0;
    bus.green_b = 1'b1;
    tick(3);
    chk_all("pre_hold_b", 2'd2, 1, 1, 0, 0);
    bus.req_a = 1'b1;
    tick();
    bus.req_a = 1'b0;
    tick(8);
    chk_all("pre_block", 2'd2, 1, 1, 0, 0);

    // releasing preempt lets the latched req_a through
    bus.preempt = 1'b0;
    tick();
    chk_all("rel_a", 2'd1, 1, 0, 1, 0);
    bus.green_b = 1'b0;
    bus.green_a = 1'b1;
    tick(3);
    chk_all("rel_hold_a", 2'd2, 1, 0, 0, 0);

    // switch toward B that never gets green_b
    bus.req_b = 1'b1;
    tick(6);
    chk_all("to_wait", 2'd2, 1, 0, 0, 0);
    tick();
    bus.req_b   = 1'b0;
    bus.green_a = 1'b0;
    chk_all("to_sw", 2'd1, 1, 1, 1, 0);
    tick(7);
    chk_all("to_pre", 2'd1, 1, 1, 1, 0);
    tick();
    chk_all("fault", 2'd3, 0, 0, 0, 1);
    bus.fault_clr = 1'b1;
    tick();
    chk_all("clr_manual", 2'd3, 0, 0, 0, 1);
    bus.mode_req = 1'b0;
    tick();
    chk_all("clr_auto", 2'd0, 0, 0, 0, 0);
    bus.fault_clr = 1'b0;

    // mode drop mid-SWITCH completes, then AUTO
    bus.mode_req = 1'b1;
    bus.green_a  = 1'b1;
    tick();
    chk_all("drop_sw", 2'd1, 1, 0, 1, 0);
    bus.mode_req = 1'b0;
    tick(2);
    chk("drop_mid", 8'(bus.state_o), 8'd1);
    tick();
    chk_all("drop_hold", 2'd2, 1, 0, 0, 0);
    tick();
    chk_all("drop_auto", 2'd0, 0, 0, 0, 0);

    // rst mid-SWITCH
    bus.mode_req = 1'b1;
    tick();
    chk_all("rst_sw", 2'd1, 1, 0, 1, 0);
    rst          = 1'b1;
    bus.mode_req = 1'b0;
    tick();
    chk_all("rst_mid", 2'd0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_all("rst_idle", 2'd0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
